// File: rtl/clock_mode_ctrl_pkg.sv
// Shared definitions for the clock mode controller: one-hot mode encodings,
// digit-select reset value and default debounce length.
package clock_mode_ctrl_pkg;

  typedef enum logic [3:0] {
    MODE_RUN       = 4'b0001,
    MODE_SET_TIME  = 4'b0010,
    MODE_SET_ALARM = 4'b0100,
    MODE_STOPWATCH = 4'b1000
  } mode_e;

  localparam logic [5:0]  SEL_RESET          = 6'b000001;
  localparam int unsigned DEB_CYCLES_DEFAULT = 20;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_RUN:       return MODE_SET_TIME;
      MODE_SET_TIME:  return MODE_SET_ALARM;
      MODE_SET_ALARM: return MODE_STOPWATCH;
      default:        return MODE_RUN;
    endcase
  endfunction

  function automatic logic is_set_mode(input mode_e m);
    return (m == MODE_SET_TIME) || (m == MODE_SET_ALARM);
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_debounce.sv
// Button debouncer: synchronises the raw input, accepts a new level after
// DEB_CYCLES consecutive differing samples, and emits a registered press strobe.
module btn_debounce
  import clock_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned   CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= i_btn;
      r_press <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Strobe is raised in the same edge the level is accepted, rising only.
        r_cnt   <= '0;
        r_level <= r_sync;
        r_press <= r_sync;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Clock user-interface controller: debounced buttons drive a four-mode FSM that
// gates timekeeping/stopwatch enables and digit-edit controls; all outputs registered.
module clock_mode_ctrl
  import clock_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_100hz,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       btn_ss,
  output logic [3:0] mode,
  output logic [5:0] sel,
  output logic       inc_pulse,
  output logic       time_tick,
  output logic       sw_tick,
  output logic       sw_clear,
  output logic       sw_run,
  output logic       blink
);

  logic w_press_mode, w_press_sel, w_press_inc, w_press_ss;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk(clk), .rst(rst), .i_btn(btn_mode), .o_press(w_press_mode));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk(clk), .rst(rst), .i_btn(btn_sel), .o_press(w_press_sel));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk(clk), .rst(rst), .i_btn(btn_inc), .o_press(w_press_inc));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk(clk), .rst(rst), .i_btn(btn_ss), .o_press(w_press_ss));

  mode_e      r_mode, w_mode_n;
  logic [5:0] r_sel, w_sel_n;
  logic       r_inc, w_inc_n;
  logic       r_time_tick, w_time_tick_n;
  logic       r_sw_tick, w_sw_tick_n;
  logic       r_sw_clear, w_sw_clear_n;
  logic       r_sw_run, w_sw_run_n;
  logic       r_blink, w_blink_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= MODE_RUN;
      r_sel       <= '0;
      r_inc       <= 1'b0;
      r_time_tick <= 1'b0;
      r_sw_tick   <= 1'b0;
      r_sw_clear  <= 1'b0;
      r_sw_run    <= 1'b0;
      r_blink     <= 1'b0;
    end else begin
      r_mode      <= w_mode_n;
      r_sel       <= w_sel_n;
      r_inc       <= w_inc_n;
      r_time_tick <= w_time_tick_n;
      r_sw_tick   <= w_sw_tick_n;
      r_sw_clear  <= w_sw_clear_n;
      r_sw_run    <= w_sw_run_n;
      r_blink     <= w_blink_n;
    end
  end

  always_comb begin
    w_mode_n      = r_mode;
    w_sel_n       = r_sel;
    w_inc_n       = 1'b0;
    w_sw_clear_n  = 1'b0;
    w_sw_run_n    = r_sw_run;
    w_blink_n     = r_blink;
    w_time_tick_n = tick_1hz && (r_mode != MODE_SET_TIME);
    w_sw_tick_n   = tick_100hz && r_sw_run;

    // A mode press swallows every other press in the same cycle.
    if (w_press_mode) begin
      w_mode_n  = next_mode(r_mode);
      w_sel_n   = is_set_mode(w_mode_n) ? SEL_RESET : '0;
      w_blink_n = 1'b0;
    end else begin
      case (r_mode)
        MODE_SET_TIME, MODE_SET_ALARM: begin
          if (w_press_sel)      w_sel_n = {r_sel[4:0], r_sel[5]};
          else if (w_press_inc) w_inc_n = 1'b1;
          if (tick_1hz)         w_blink_n = ~r_blink;
        end
        MODE_STOPWATCH: begin
          if (w_press_ss)                w_sw_run_n   = ~r_sw_run;
          if (w_press_sel && !r_sw_run)  w_sw_clear_n = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mode      = r_mode;
  assign sel       = r_sel;
  assign inc_pulse = r_inc;
  assign time_tick = r_time_tick;
  assign sw_tick   = r_sw_tick;
  assign sw_clear  = r_sw_clear;
  assign sw_run    = r_sw_run;
  assign blink     = r_blink;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: a behavioural model predicts every
// output cycle from the raw stimulus; a monitor pops and compares each cycle.
module tb_clock_mode_ctrl;

  localparam int unsigned D = 20;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, tick_100hz, btn_mode, btn_sel, btn_inc, btn_ss;
  logic [3:0] mode;
  logic [5:0] sel;
  logic       inc_pulse, time_tick, sw_tick, sw_clear, sw_run, blink;

  clock_mode_ctrl #(.DEB_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_100hz(tick_100hz),
    .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_inc(btn_inc), .btn_ss(btn_ss),
    .mode(mode), .sel(sel), .inc_pulse(inc_pulse), .time_tick(time_tick),
    .sw_tick(sw_tick), .sw_clear(sw_clear), .sw_run(sw_run), .blink(blink));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mode;
    logic [5:0] sel;
    logic       inc, tt, st, clr, run, blink;
  } out_t;

  out_t        exp_q[$];
  int unsigned n_checks = 0, n_pass = 0;
  int          g_edge = 0;
  int          cnt_inc = 0, cnt_tt = 0, cnt_st = 0, cnt_clr = 0;
  int          last_inc_edge = -1, last_rise_edge = -1;
  int          t1_per = 0;
  bit          m_t1 = 0, m_t100 = 0, rnd_ticks = 0;

  // Reference model: mode index 0..3, digit index 0..5, debounce by history window.
  int m_idx = 0, m_digit = 0;
  bit m_run = 0, m_blink = 0;
  bit m_lvl[4], m_pd[4];
  bit m_hist[4][$];

  function automatic out_t model_step(input bit r, input bit [3:0] raw,
                                      input bit t1, input bit t100);
    out_t     o;
    bit [3:0] np;
    bit       all_diff;
    o = '0;
    if (r) begin
      m_idx = 0; m_digit = 0; m_run = 0; m_blink = 0;
      for (int b = 0; b < 4; b++) begin
        m_lvl[b] = 0; m_pd[b] = 0;
        m_hist[b].delete();
        m_hist[b].push_back(1'b0);
      end
      o.mode = 4'b0001;
      return o;
    end
    np = '0;
    for (int b = 0; b < 4; b++) begin
      if (m_hist[b].size() >= D) begin
        all_diff = 1;
        for (int k = 0; k < int'(D); k++)
          if (m_hist[b][m_hist[b].size() - 1 - k] == m_lvl[b]) all_diff = 0;
        if (all_diff) begin
          m_lvl[b] = !m_lvl[b];
          np[b]    = m_lvl[b];
        end
      end
    end
    o.tt = t1 && (m_idx != 1);
    o.st = t100 && m_run;
    if (m_pd[0]) begin
      m_idx = (m_idx + 1) % 4; m_digit = 0; m_blink = 0;
    end else if (m_idx == 1 || m_idx == 2) begin
      if (m_pd[1]) m_digit = (m_digit + 1) % 6;
      else if (m_pd[2]) o.inc = 1;
      if (t1) m_blink = !m_blink;
    end else if (m_idx == 3) begin
      if (m_pd[1] && !m_run) o.clr = 1;
      if (m_pd[3]) m_run = !m_run;
    end
    for (int b = 0; b < 4; b++) begin
      m_pd[b] = np[b];
      m_hist[b].push_back(raw[b]);
      if (m_hist[b].size() > D) void'(m_hist[b].pop_front());
    end
    o.mode  = 4'(1 << m_idx);
    o.sel   = (m_idx == 1 || m_idx == 2) ? 6'(1 << m_digit) : 6'b0;
    o.run   = m_run;
    o.blink = m_blink;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, g_edge);
  endtask

  task automatic cycle();
    out_t e;
    tick_1hz   = m_t1 || (t1_per != 0 && (g_edge % t1_per) == 0) ||
                 (rnd_ticks && $urandom_range(0, 39) == 0);
    tick_100hz = m_t100 || (rnd_ticks && $urandom_range(0, 5) == 0);
    m_t1 = 0; m_t100 = 0;
    e = model_step(rst, {btn_ss, btn_inc, btn_sel, btn_mode}, tick_1hz, tick_100hz);
    @(posedge clk);
    g_edge++;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: begin if (v && !btn_mode) last_rise_edge = g_edge; btn_mode = v; end
      1: begin if (v && !btn_sel)  last_rise_edge = g_edge; btn_sel  = v; end
      2: begin if (v && !btn_inc)  last_rise_edge = g_edge; btn_inc  = v; end
      default: begin if (v && !btn_ss) last_rise_edge = g_edge; btn_ss = v; end
    endcase
  endtask

  task automatic press(input int b, input int bounce, input int hold);
    for (int i = 0; i < bounce; i++) begin
      set_btn(b, (i % 2) == 0);
      repeat ($urandom_range(1, 5)) cycle();
    end
    set_btn(b, 1'b1);
    repeat (hold) cycle();
    set_btn(b, 1'b0);
    repeat (D + 6) cycle();
  endtask

  // Monitor: one expected entry per clock edge, compared on the falling edge.
  initial begin
    out_t e, act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {mode, sel, inc_pulse, time_tick, sw_tick, sw_clear, sw_run, blink};
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL outputs edge=%0d got=%h expected=%h", g_edge, act, e);
        if (inc_pulse === 1'b1) begin cnt_inc++; last_inc_edge = g_edge; end
        if (time_tick === 1'b1) cnt_tt++;
        if (sw_tick === 1'b1)   cnt_st++;
        if (sw_clear === 1'b1)  cnt_clr++;
      end
    end
  end

  initial begin
    logic [3:0] mode_seq[4];
    logic [5:0] sel_seq[7];
    mode_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    sel_seq  = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001, 6'b000010};
    rst = 1; btn_mode = 0; btn_sel = 0; btn_inc = 0; btn_ss = 0;
    tick_1hz = 0; tick_100hz = 0;
    repeat (3) cycle();
    check("reset_state", {mode, sel, inc_pulse, time_tick, sw_tick, sw_clear, sw_run, blink}, 16'h1000);
    rst = 0;
    repeat (5) cycle();

    for (int i = 0; i < 4; i++) begin
      press(0, 0, D + 6);
      check("mode_step", mode, mode_seq[i]);
    end

    press(0, 0, D + 6);
    check("enter_set_time_sel", {sel, blink}, {6'b000001, 1'b0});
    cnt_inc = 0;
    for (int i = 0; i < 50; i++) begin
      set_btn(2, ((i / 3) % 2) == 0);
      cycle();
    end
    repeat (25) cycle();
    set_btn(2, 1'b0);
    repeat (D + 6) cycle();
    check("bounce_inc_count", cnt_inc, 1);
    check("bounce_latency", last_inc_edge - last_rise_edge, D + 2);

    cnt_tt = 0; t1_per = 100;
    repeat (1000) cycle();
    t1_per = 0;
    check("freeze_time_tick", cnt_tt, 0);

    press(0, 0, D + 6);
    t1_per = 37;
    for (int i = 0; i < 7; i++) begin
      press(1, $urandom_range(0, 3), D + 6);
      check("sel_rotate", sel, sel_seq[i]);
    end
    t1_per = 0;

    press(0, 0, D + 6);
    press(0, 0, D + 6);
    check("back_to_run", mode, 4'b0001);
    m_t1 = 1;
    cycle();
    check("time_follow_hi", time_tick, 1);
    cycle();
    check("time_follow_lo", time_tick, 0);

    repeat (3) press(0, 0, D + 6);
    cnt_st = 0;
    press(3, 2, D + 6);
    check("sw_run_on", sw_run, 1);
    repeat (5) begin m_t100 = 1; cycle(); repeat (3) cycle(); end
    press(0, 0, D + 6);
    repeat (3) begin m_t100 = 1; cycle(); repeat (3) cycle(); end
    check("sw_tick_count", cnt_st, 8);
    repeat (3) press(0, 0, D + 6);
    cnt_clr = 0;
    press(3, 0, D + 6);
    press(1, 0, D + 6);
    check("sw_run_off", sw_run, 0);
    check("sw_clear_count", cnt_clr, 1);

    press(0, 0, D + 6);
    press(0, 0, D + 6);
    cnt_inc = 0;
    set_btn(0, 1'b1); set_btn(2, 1'b1);
    repeat (D + 6) cycle();
    set_btn(0, 1'b0); set_btn(2, 1'b0);
    repeat (D + 6) cycle();
    check("simul_mode", mode, 4'b0100);
    check("simul_no_inc", cnt_inc, 0);

    press(1, 0, D + 6);
    t1_per = 7;
    set_btn(2, 1'b1);
    repeat (D + 1) cycle();
    rst = 1;
    cycle();
    check("reset_mid_edit", {mode, sel, inc_pulse, time_tick, sw_tick, sw_clear, sw_run, blink}, 16'h1000);
    rst = 0; cnt_inc = 0; cnt_clr = 0;
    repeat (D + 10) cycle();
    set_btn(2, 1'b0);
    repeat (D + 6) cycle();
    check("no_residual_inc", cnt_inc, 0);
    t1_per = 0;

    rnd_ticks = 1;
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      press((r < 3) ? 0 : (r < 6) ? 1 : (r < 8) ? 2 : 3,
            $urandom_range(0, 4), $urandom_range(D + 3, D + 20));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1; cycle(); rst = 0;
      end
    end
    rnd_ticks = 0;
    repeat (5) cycle();
    #10;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
